// File: rtl/gcm_aes_pkg.sv
// Shared definitions for the GCM-AES output collector: block width,
// collector FSM state encoding and the partial-word byte-mask helper.
package gcm_aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DATA     = 2'd1,
        ST_TAG_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Byte 0 sits in the top byte lane, so a word carrying size+1 bytes
    // keeps its upper (size+1) bytes. Shifting an all-ones word left by
    // 8*(15-size) leaves exactly those lanes set; 15-size is ~size in 4 bits.
    function automatic logic [BLOCK_W-1:0] byte_mask(input logic [3:0] size);
        logic [6:0] shift_amt;
        shift_amt = {~size, 3'b000};
        return {BLOCK_W{1'b1}} << shift_amt;
    endfunction

endpackage

// File: rtl/gcm_aes_out_collector_if.sv
// Stream interface between the GCM-AES core output, the collector and the
// host-side reader.
//
// Handshake: the core side has no backpressure -- a word is transferred in
// every cycle Out_vld (or Tag_vld) is high. The reader side is valid/ready:
// rd_vld means rd_data holds the FIFO head; a word is popped in a cycle where
// rd_vld and rd_en are both high. rd_en while rd_vld is low has no effect.
interface gcm_aes_out_collector_if;
    import gcm_aes_pkg::*;

    logic [BLOCK_W-1:0] Out_data;
    logic               Out_vld;
    logic               Tag_vld;
    logic [3:0]         Out_data_size;
    logic               Out_last_word;
    logic               rd_en;
    logic [BLOCK_W-1:0] rd_data;
    logic               rd_vld;

    modport master (
        output Out_data, Out_vld, Tag_vld, Out_data_size, Out_last_word, rd_en,
        input  rd_data, rd_vld
    );

    modport slave (
        input  Out_data, Out_vld, Tag_vld, Out_data_size, Out_last_word, rd_en,
        output rd_data, rd_vld
    );

endinterface

// File: rtl/gcm_out_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is presented
// combinationally from registered storage; an empty FIFO reads as zero.
// A pop and a push in the same cycle both succeed even when full.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module gcm_out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_rd;
    logic         w_do_wr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // An empty FIFO ignores rd_en (no bypass); a full FIFO accepts a write
    // only when the same cycle frees a slot.
    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the empty flag masks them.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/gcm_aes_out_collector.sv
// Collector for the GCM-AES core output stream: masks partial words,
// buffers payload words in a FWFT FIFO, counts payload bytes, captures the
// tag and reports message completion.
// Optional tag compare is built when GCM_OUT_TAG_CHECK_EN is defined;
// otherwise tag_ok is tied low and exp_tag is unused.
module gcm_aes_out_collector
    import gcm_aes_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    gcm_aes_out_collector_if.slave bus,
    input  logic                   done_ack,
    input  logic [BLOCK_W-1:0]     exp_tag,
    output logic [CNT_W-1:0]       byte_cnt,
    output logic [BLOCK_W-1:0]     tag,
    output logic                   msg_done,
    output logic                   overflow,
    output logic                   tag_ok,
    output state_t                 dbg_state
);

    state_t             r_state;
    state_t             w_next;
    logic               w_wr;
    logic               w_cap;
    logic               w_late_word;
    logic               w_ack;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_drop;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [CNT_W:0]     w_cnt_sum;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [BLOCK_W-1:0] r_tag;
    logic               r_overflow;

    // Next-state and per-cycle strobes; Tag_vld outranks Out_vld everywhere.
    always_comb begin
        w_next      = r_state;
        w_wr        = 1'b0;
        w_cap       = 1'b0;
        w_late_word = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA: begin
                if (bus.Tag_vld) begin
                    w_cap  = 1'b1;
                    w_next = ST_DONE;
                end else if (bus.Out_vld) begin
                    w_wr   = 1'b1;
                    w_next = bus.Out_last_word ? ST_TAG_WAIT : ST_DATA;
                end
            end
            ST_TAG_WAIT: begin
                if (bus.Tag_vld) begin
                    w_cap  = 1'b1;
                    w_next = ST_DONE;
                end else if (bus.Out_vld) begin
                    w_late_word = 1'b1;
                end
            end
            ST_DONE: begin
                if (done_ack) begin
                    w_ack  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    gcm_out_fifo #(
        .DEPTH (DEPTH),
        .W     (BLOCK_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_data (bus.Out_data & byte_mask(bus.Out_data_size)),
        .i_rd_en   (bus.rd_en),
        .o_rd_data (bus.rd_data),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    assign bus.rd_vld = !w_empty;
    assign w_pop      = bus.rd_en && !w_empty;
    assign w_drop     = w_wr && w_full && !w_pop;

    // One extra bit catches the carry so the count can saturate.
    assign w_cnt_sum  = {1'b0, r_byte_cnt}
                      + {{(CNT_W-3){1'b0}}, bus.Out_data_size}
                      + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    // Payload byte counter, cleared when the controller acknowledges.
    always_ff @(posedge clk) begin
        if (rst || w_ack) r_byte_cnt <= '0;
        else if (w_wr)    r_byte_cnt <= w_cnt_next;
    end

    // Tag capture; the tag stays visible after acknowledge.
    always_ff @(posedge clk) begin
        if (rst)        r_tag <= '0;
        else if (w_cap) r_tag <= bus.Out_data;
    end

    // Sticky overflow: a dropped FIFO write or a payload word after the last.
    always_ff @(posedge clk) begin
        if (rst)                        r_overflow <= 1'b0;
        else if (w_drop || w_late_word) r_overflow <= 1'b1;
    end

`ifdef GCM_OUT_TAG_CHECK_EN
    logic r_tag_ok;

    // Tag compare result, registered in the same cycle msg_done rises.
    always_ff @(posedge clk) begin
        if (rst || w_ack) r_tag_ok <= 1'b0;
        else if (w_cap)   r_tag_ok <= (bus.Out_data == exp_tag);
    end

    assign tag_ok = r_tag_ok;
`else
    logic w_unused_exp_tag;
    assign w_unused_exp_tag = ^exp_tag;
    assign tag_ok = 1'b0;
`endif

    assign byte_cnt  = r_byte_cnt;
    assign tag       = r_tag;
    assign msg_done  = (r_state == ST_DONE);
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gcm_aes_out_collector.sv
// Directed bench for gcm_aes_out_collector: a table of single-word
// messages plus hand-written multi-cycle sequences (multi-word, tag only,
// overflow, full with pop, reset mid-message).
module tb_gcm_aes_out_collector;
    import gcm_aes_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef GCM_OUT_TAG_CHECK_EN
    localparam bit TAG_CHK = 1'b1;
`else
    localparam bit TAG_CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcm_aes_out_collector_if bus_if ();
    logic               done_ack;
    logic [BLOCK_W-1:0] exp_tag;
    logic [CNT_W-1:0]   byte_cnt;
    logic [BLOCK_W-1:0] tag;
    logic               msg_done;
    logic               overflow;
    logic               tag_ok;
    state_t             dbg_state;

    gcm_aes_out_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .done_ack  (done_ack),
        .exp_tag   (exp_tag),
        .byte_cnt  (byte_cnt),
        .tag       (tag),
        .msg_done  (msg_done),
        .overflow  (overflow),
        .tag_ok    (tag_ok),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [BLOCK_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.Out_data      = '0;
        bus_if.Out_vld       = 1'b0;
        bus_if.Tag_vld       = 1'b0;
        bus_if.Out_data_size = 4'h0;
        bus_if.Out_last_word = 1'b0;
        bus_if.rd_en         = 1'b0;
        done_ack             = 1'b0;
        exp_tag              = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [127:0] d, input logic [3:0] sz, input logic last);
        bus_if.Out_data      = d;
        bus_if.Out_data_size = sz;
        bus_if.Out_last_word = last;
        bus_if.Out_vld       = 1'b1;
        tick();
        bus_if.Out_vld       = 1'b0;
        bus_if.Out_last_word = 1'b0;
        bus_if.Out_data      = '0;
    endtask

    task automatic send_tag(input logic [127:0] t, input logic [127:0] et);
        bus_if.Out_data = t;
        exp_tag         = et;
        bus_if.Tag_vld  = 1'b1;
        tick();
        bus_if.Tag_vld  = 1'b0;
        bus_if.Out_data = '0;
        exp_tag         = '0;
    endtask

    task automatic ack();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
    endtask

    // Pops the head and compares it with the oldest expected word.
    task automatic pop_check(input string name);
        logic [127:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({name, "_vld"}, 128'(bus_if.rd_vld), 128'(1'b1));
        chk({name, "_data"}, bus_if.rd_data, e);
        bus_if.rd_en = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rd_vld"},   128'(bus_if.rd_vld), 128'(1'b0));
        chk({name, "_rd_data"},  bus_if.rd_data, '0);
        chk({name, "_byte_cnt"}, 128'(byte_cnt), 128'(0));
        chk({name, "_tag"},      tag, '0);
        chk({name, "_msg_done"}, 128'(msg_done), 128'(1'b0));
        chk({name, "_overflow"}, 128'(overflow), 128'(1'b0));
        chk({name, "_tag_ok"},   128'(tag_ok), 128'(1'b0));
        chk({name, "_state"},    128'(dbg_state), 128'(ST_IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [127:0] data;
        logic [3:0]   size;
        logic [127:0] exp_word;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vecs[5];

    localparam logic [127:0] T_A = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    initial begin
        vecs[0] = '{data: {128{1'b1}}, size: 4'h3,
                    exp_word: 128'hffffffff_00000000_00000000_00000000, exp_cnt: 16'd4};
        vecs[1] = '{data: 128'h00112233_44556677_8899aabb_ccddeeff, size: 4'hF,
                    exp_word: 128'h00112233_44556677_8899aabb_ccddeeff, exp_cnt: 16'd16};
        vecs[2] = '{data: 128'hdeadbeef_01234567_89abcdef_cafef00d, size: 4'h0,
                    exp_word: 128'hde000000_00000000_00000000_00000000, exp_cnt: 16'd1};
        vecs[3] = '{data: 128'hdeadbeef_01234567_89abcdef_cafef00d, size: 4'h7,
                    exp_word: 128'hdeadbeef_01234567_00000000_00000000, exp_cnt: 16'd8};
        vecs[4] = '{data: 128'hdeadbeef_01234567_89abcdef_cafef00d, size: 4'hE,
                    exp_word: 128'hdeadbeef_01234567_89abcdef_cafef000, exp_cnt: 16'd15};

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Two full words, last on the second, then the tag.
        send_word(128'h11111111_22222222_33333333_44444444, 4'hF, 1'b0);
        exp_q.push_back(128'h11111111_22222222_33333333_44444444);
        chk("two_st_data", 128'(dbg_state), 128'(ST_DATA));
        chk("two_rd_vld_after_wr", 128'(bus_if.rd_vld), 128'(1'b1));
        send_word(128'h55555555_66666666_77777777_88888888, 4'hF, 1'b1);
        exp_q.push_back(128'h55555555_66666666_77777777_88888888);
        chk("two_st_tagwait", 128'(dbg_state), 128'(ST_TAG_WAIT));
        chk("two_done_early", 128'(msg_done), 128'(1'b0));
        send_tag(T_A, T_A);
        chk("two_msg_done", 128'(msg_done), 128'(1'b1));
        chk("two_byte_cnt", 128'(byte_cnt), 128'(32));
        chk("two_tag", tag, T_A);
        chk("two_tag_ok", 128'(tag_ok), 128'(TAG_CHK));
        pop_check("two_w0");
        pop_check("two_w1");
        chk("two_empty", 128'(bus_if.rd_vld), 128'(1'b0));
        ack();
        chk("two_ack_done", 128'(msg_done), 128'(1'b0));
        chk("two_ack_cnt", 128'(byte_cnt), 128'(0));
        chk("two_ack_tag_ok", 128'(tag_ok), 128'(1'b0));
        chk("two_ack_state", 128'(dbg_state), 128'(ST_IDLE));
        chk("two_tag_kept", tag, T_A);

        // Single-word messages with every interesting size.
        for (int i = 0; i < 5; i++) begin
            send_word(vecs[i].data, vecs[i].size, 1'b1);
            exp_q.push_back(vecs[i].exp_word);
            send_tag(T_A ^ 128'(i), T_A ^ 128'(i));
            chk($sformatf("vec%0d_cnt", i), 128'(byte_cnt), 128'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_done", i), 128'(msg_done), 128'(1'b1));
            chk($sformatf("vec%0d_tag", i), tag, T_A ^ 128'(i));
            pop_check($sformatf("vec%0d_pop", i));
            ack();
        end

        // One full word then a 4-byte final word of all 0xFF: 16*1+4 bytes.
        send_word(128'hcafebabe_cafebabe_cafebabe_cafebabe, 4'hF, 1'b0);
        exp_q.push_back(128'hcafebabe_cafebabe_cafebabe_cafebabe);
        send_word({128{1'b1}}, 4'h3, 1'b1);
        exp_q.push_back(128'hffffffff_00000000_00000000_00000000);
        send_tag(T_A, T_A);
        chk("part_cnt", 128'(byte_cnt), 128'(20));
        pop_check("part_w0");
        pop_check("part_w1");
        ack();

        // Tag only from IDLE, with a one-bit-off expected tag.
        send_tag(T_A, T_A ^ 128'h1);
        chk("tagonly_done", 128'(msg_done), 128'(1'b1));
        chk("tagonly_cnt", 128'(byte_cnt), 128'(0));
        chk("tagonly_rd_vld", 128'(bus_if.rd_vld), 128'(1'b0));
        chk("tagonly_tag_ok", 128'(tag_ok), 128'(1'b0));
        ack();
        chk("tagonly_ack_state", 128'(dbg_state), 128'(ST_IDLE));

        // Tag and payload together count as tag only; DONE ignores payload.
        bus_if.Out_vld       = 1'b1;
        bus_if.Out_data_size = 4'hF;
        send_tag(T_A, T_A);
        bus_if.Out_vld       = 1'b0;
        chk("both_done", 128'(msg_done), 128'(1'b1));
        chk("both_no_write", 128'(bus_if.rd_vld), 128'(1'b0));
        send_word(128'h1234, 4'hF, 1'b1);
        chk("done_ignores_vld", 128'(bus_if.rd_vld), 128'(1'b0));
        chk("done_ignores_cnt", 128'(byte_cnt), 128'(0));
        chk("done_holds", 128'(dbg_state), 128'(ST_DONE));
        ack();

        // Write into an empty FIFO with rd_en high: the read is ignored.
        bus_if.rd_en = 1'b1;
        send_word(128'habcdef01_00000000_00000000_00000001, 4'hF, 1'b1);
        bus_if.rd_en = 1'b0;
        exp_q.push_back(128'habcdef01_00000000_00000000_00000001);
        chk("empty_rd_ignored", 128'(bus_if.rd_vld), 128'(1'b1));
        // A payload word after the last one flags overflow and is not stored.
        send_word(128'h99, 4'hF, 1'b0);
        chk("late_word_ovf", 128'(overflow), 128'(1'b1));
        chk("late_word_state", 128'(dbg_state), 128'(ST_TAG_WAIT));
        pop_check("empty_rd_pop");
        chk("late_word_not_stored", 128'(bus_if.rd_vld), 128'(1'b0));
        send_tag(T_A, T_A);
        ack();
        do_reset();
        chk("ovf_cleared_by_rst", 128'(overflow), 128'(1'b0));

        // DEPTH+1 writes with no reads: last one dropped, overflow sticky.
        for (int i = 0; i <= DEPTH; i++) begin
            send_word(128'h100 + 128'(i), 4'hF, 1'b0);
            if (i < DEPTH) exp_q.push_back(128'h100 + 128'(i));
            if (i == DEPTH - 1) chk("fill_no_ovf", 128'(overflow), 128'(1'b0));
        end
        chk("fill_ovf", 128'(overflow), 128'(1'b1));
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("fill_pop%0d", i));
        chk("fill_drained", 128'(bus_if.rd_vld), 128'(1'b0));
        chk("fill_ovf_sticky", 128'(overflow), 128'(1'b1));
        send_tag(T_A, T_A);
        ack();
        do_reset();

        // Same fill, but pop on the full cycle: both succeed, no overflow.
        for (int i = 0; i < DEPTH; i++) begin
            send_word(128'h200 + 128'(i), 4'hF, 1'b0);
            exp_q.push_back(128'h200 + 128'(i));
        end
        chk("full_head", bus_if.rd_data, 128'h200);
        void'(exp_q.pop_front());
        bus_if.rd_en = 1'b1;
        send_word(128'h200 + 128'(DEPTH), 4'hF, 1'b1);
        bus_if.rd_en = 1'b0;
        exp_q.push_back(128'h200 + 128'(DEPTH));
        chk("full_pop_no_ovf", 128'(overflow), 128'(1'b0));
        for (int i = 1; i <= DEPTH; i++) pop_check($sformatf("full_pop%0d", i));
        chk("full_drained", 128'(bus_if.rd_vld), 128'(1'b0));
        send_tag(T_A, T_A);
        chk("full_cnt", 128'(byte_cnt), 128'(16 * (DEPTH + 1)));
        ack();

        // Reset in the middle of a message discards everything.
        send_word(128'h777, 4'hF, 1'b0);
        send_word(128'h888, 4'h7, 1'b0);
        do_reset();
        chk_reset_outputs("midrst");
        send_word(128'hfeedface_00000000_00000000_0000beef, 4'hB, 1'b1);
        exp_q.push_back(128'hfeedface_00000000_00000000_00000000);
        send_tag(~T_A, ~T_A);
        chk("midrst_cnt", 128'(byte_cnt), 128'(12));
        chk("midrst_tag", tag, ~T_A);
        chk("midrst_tag_ok", 128'(tag_ok), 128'(TAG_CHK));
        pop_check("midrst_pop");
        chk("midrst_drained", 128'(bus_if.rd_vld), 128'(1'b0));
        ack();

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
